pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/ras_stack.sv | 62 ++++++
 rtl/pc_fetch_unit.sv | 102 ++++++++++
 tb/tb_pc_fetch_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline definitions: next-PC select encoding, reset constants
// and return-address-stack sizing.
package pipeline_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RAS_DEPTH = 8;
  localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);

  localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    PC_SEQ      = 3'b000,
    PC_JUMP     = 3'b001,
    PC_BRANCH   = 3'b010,
    PC_CALL_RS1 = 3'b011,
    PC_RET      = 3'b100
  } pc_src_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty only raises the sticky underflow flag.
module ras_stack
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty,
  output logic            o_full,
  output logic            o_underflow
);

  localparam logic [RAS_PTR_W:0] C_FULL_CNT = (RAS_PTR_W + 1)'(RAS_DEPTH);

  logic [XLEN-1:0]      r_mem [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] r_top_ptr;
  logic [RAS_PTR_W:0]   r_count;
  logic                 r_underflow;
  logic [RAS_PTR_W-1:0] w_push_ptr;
  logic                 w_do_push;

  // A simultaneous pop wins; the push is dropped.
  assign w_do_push   = i_push && !i_pop;
  assign w_push_ptr  = r_top_ptr + 1'b1;

  assign o_top       = r_mem[r_top_ptr];
  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == C_FULL_CNT);
  assign o_underflow = r_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top_ptr   <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else if (i_pop) begin
      if (r_count != '0) begin
        r_top_ptr <= r_top_ptr - 1'b1;
        r_count   <= r_count - 1'b1;
      end else begin
        r_underflow <= 1'b1;
      end
    end else if (w_do_push) begin
      r_top_ptr <= w_push_ptr;
      if (r_count != C_FULL_CNT) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Entry storage carries data only; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_push_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: PC register, next-PC selection with RAS-backed returns,
// and the IF/ID pipeline register with kill (bubble) and stall (hold).
module pc_fetch_unit
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      PcSource,
  input  logic            SIG_Kill,
  input  logic            SIG_Stall,
  input  logic            SIG_RasPush,
  input  logic [XLEN-1:0] ResolvePc,
  input  logic [XLEN-1:0] JumpTarget,
  input  logic [XLEN-1:0] BranchTarget,
  input  logic [XLEN-1:0] Rs1Target,
  input  logic [XLEN-1:0] InstrIn,
  output logic [XLEN-1:0] PcOut,
  output logic [XLEN-1:0] IfIdPc,
  output logic [XLEN-1:0] IfIdInstr,
  output logic            IfIdValid,
  output logic            RasEmpty,
  output logic            RasFull,
  output logic            RasUnderflow
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ifid_pc;
  logic [XLEN-1:0] r_ifid_instr;
  logic            r_ifid_valid;
  logic            r_started;

  pc_src_e         w_src;
  logic            w_run;
  logic            w_ret_sel;
  logic            w_pop;
  logic            w_push;
  logic [XLEN-1:0] w_ret_addr;
  logic [XLEN-1:0] w_ras_top;
  logic [XLEN-1:0] w_ret_target;
  logic [XLEN-1:0] w_next_pc;

  // The first edge after reset release only arms fetch; nothing advances on it.
  assign w_src        = pc_src_e'(PcSource);
  assign w_run        = r_started && !SIG_Stall;
  assign w_ret_sel    = (w_src == PC_RET);
  assign w_pop        = w_run && w_ret_sel;
  assign w_push       = w_run && SIG_RasPush;
  assign w_ret_addr   = ResolvePc + 32'd4;
  assign w_ret_target = RasEmpty ? w_ret_addr : w_ras_top;

  always_comb begin
    w_next_pc = r_pc + 32'd4;
    case (w_src)
      PC_JUMP:     w_next_pc = JumpTarget;
      PC_BRANCH:   w_next_pc = BranchTarget;
      PC_CALL_RS1: w_next_pc = Rs1Target;
      PC_RET:      w_next_pc = w_ret_target;
      default:     w_next_pc = r_pc + 32'd4;
    endcase
  end

  ras_stack u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      (w_ret_addr),
    .o_top       (w_ras_top),
    .o_empty     (RasEmpty),
    .o_full      (RasFull),
    .o_underflow (RasUnderflow)
  );

  // IF -> ID stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started    <= 1'b0;
      r_pc         <= RESET_PC;
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP;
      r_ifid_valid <= 1'b0;
    end else if (!r_started) begin
      r_started <= 1'b1;
    end else if (!SIG_Stall) begin
      r_pc      <= align_word(w_next_pc);
      r_ifid_pc <= r_pc;
      if (SIG_Kill) begin
        r_ifid_instr <= NOP;
        r_ifid_valid <= 1'b0;
      end else begin
        r_ifid_instr <= InstrIn;
        r_ifid_valid <= 1'b1;
      end
    end
  end

  assign PcOut     = r_pc;
  assign IfIdPc    = r_ifid_pc;
  assign IfIdInstr = r_ifid_instr;
  assign IfIdValid = r_ifid_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a behavioural model pushes expected
// outputs into a scoreboard queue that is popped after every clock edge.
module tb_pc_fetch_unit;

  localparam logic [31:0] MAGIC = 32'h1357_9BDF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        empty;
    logic        full;
    logic        uf;
  } obs_t;

  localparam obs_t RST_OBS = '{pc: 32'h0, ifid_pc: 32'h0, ifid_instr: 32'h0,
                               ifid_valid: 1'b0, empty: 1'b1, full: 1'b0, uf: 1'b0};

  logic        clk;
  logic        rst_n;
  logic [2:0]  PcSource;
  logic        SIG_Kill, SIG_Stall, SIG_RasPush;
  logic [31:0] ResolvePc, JumpTarget, BranchTarget, Rs1Target, InstrIn;
  logic [31:0] PcOut, IfIdPc, IfIdInstr;
  logic        IfIdValid, RasEmpty, RasFull, RasUnderflow;

  int   n_cmp;
  int   n_fail;
  obs_t sb[$];
  obs_t exp_o;
  obs_t act_o;

  // Reference model state
  logic [31:0] m_pc, m_ifpc, m_ifinstr;
  logic        m_ifvld, m_uf, m_started;
  logic [31:0] m_ras[$];

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PcSource     (PcSource),
    .SIG_Kill     (SIG_Kill),
    .SIG_Stall    (SIG_Stall),
    .SIG_RasPush  (SIG_RasPush),
    .ResolvePc    (ResolvePc),
    .JumpTarget   (JumpTarget),
    .BranchTarget (BranchTarget),
    .Rs1Target    (Rs1Target),
    .InstrIn      (InstrIn),
    .PcOut        (PcOut),
    .IfIdPc       (IfIdPc),
    .IfIdInstr    (IfIdInstr),
    .IfIdValid    (IfIdValid),
    .RasEmpty     (RasEmpty),
    .RasFull      (RasFull),
    .RasUnderflow (RasUnderflow)
  );

  // Instruction memory stand-in: data is a fixed function of the address.
  assign InstrIn = PcOut ^ MAGIC;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample_dut();
    return '{pc: PcOut, ifid_pc: IfIdPc, ifid_instr: IfIdInstr, ifid_valid: IfIdValid,
             empty: RasEmpty, full: RasFull, uf: RasUnderflow};
  endfunction

  function automatic obs_t model_obs();
    return '{pc: m_pc, ifid_pc: m_ifpc, ifid_instr: m_ifinstr, ifid_valid: m_ifvld,
             empty: (m_ras.size() == 0), full: (m_ras.size() == 8), uf: m_uf};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_ifinstr = 32'h0;
    m_ifvld = 1'b0; m_uf = 1'b0; m_started = 1'b0;
    m_ras.delete();
    sb.delete();
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected outputs.
  task automatic cycle(input logic [2:0] src, input logic kill, input logic stall,
                       input logic push, input logic [31:0] rpc, input logic [31:0] jt,
                       input logic [31:0] bt, input logic [31:0] rt);
    logic [31:0] nxt;
    logic [31:0] tgt;
    PcSource = src; SIG_Kill = kill; SIG_Stall = stall; SIG_RasPush = push;
    ResolvePc = rpc; JumpTarget = jt; BranchTarget = bt; Rs1Target = rt;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (!stall) begin
      tgt = rpc + 32'd4;
      if (src == 3'b100) begin
        if (m_ras.size() > 0) tgt = m_ras.pop_back();
        else m_uf = 1'b1;
      end else if (push) begin
        if (m_ras.size() == 8) void'(m_ras.pop_front());
        m_ras.push_back(rpc + 32'd4);
      end
      case (src)
        3'b001:  nxt = jt;
        3'b010:  nxt = bt;
        3'b011:  nxt = rt;
        3'b100:  nxt = tgt;
        default: nxt = m_pc + 32'd4;
      endcase
      nxt[1:0]  = 2'b00;
      m_ifpc    = m_pc;
      m_ifinstr = kill ? 32'h0 : (m_pc ^ MAGIC);
      m_ifvld   = !kill;
      m_pc      = nxt;
    end
    sb.push_back(model_obs());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    PcSource = 3'b000; SIG_Kill = 1'b0; SIG_Stall = 1'b0; SIG_RasPush = 1'b0;
    ResolvePc = 32'h0; JumpTarget = 32'h0; BranchTarget = 32'h0; Rs1Target = 32'h0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    act_o = sample_dut();
    n_cmp++;
    if (act_o !== RST_OBS) begin
      n_fail++;
      $display("FAIL reset_state got %h want %h", act_o, RST_OBS);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] pc_tab [4];
    logic        vld_tab [4];
    pc_tab  = '{32'h0, 32'h4, 32'h8, 32'hC};
    vld_tab = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      exp_o = sb.pop_front();
      act_o = sample_dut();
      n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL seq_sb[%0d] got %h want %h", i, act_o, exp_o);
      end
      n_cmp++;
      if (PcOut !== pc_tab[i] || IfIdValid !== vld_tab[i]) begin
        n_fail++;
        $display("FAIL seq_pc[%0d] got pc=%h vld=%b want pc=%h vld=%b",
                 i, PcOut, IfIdValid, pc_tab[i], vld_tab[i]);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) cycle(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      else if (i == 3) cycle(3'b010, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 32'h40, 32'h0);
      else cycle(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      exp_o = sb.pop_front();
      act_o = sample_dut();
      n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL branch_sb[%0d] got %h want %h", i, act_o, exp_o);
      end
      if (i == 3) begin
        n_cmp++;
        if (PcOut !== 32'h40 || IfIdInstr !== 32'h0 || IfIdValid !== 1'b0) begin
          n_fail++;
          $display("FAIL branch_redirect got pc=%h instr=%h vld=%b want pc=00000040 instr=00000000 vld=0",
                   PcOut, IfIdInstr, IfIdValid);
        end
      end
    end
  endtask

  task automatic test_stall_kill();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) cycle(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      else if (i < 5) cycle(3'b001, 1'b1, 1'b1, 1'b1, 32'h4, 32'h203, 32'h0, 32'h0);
      else cycle(3'b001, 1'b1, 1'b0, 1'b0, 32'h4, 32'h203, 32'h0, 32'h0);
      exp_o = sb.pop_front();
      act_o = sample_dut();
      n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL stall_sb[%0d] got %h want %h", i, act_o, exp_o);
      end
      if (i == 4) begin
        n_cmp++;
        if (PcOut !== 32'h8 || IfIdPc !== 32'h4 || IfIdValid !== 1'b1 || RasEmpty !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold got pc=%h ifpc=%h vld=%b empty=%b want pc=00000008 ifpc=00000004 vld=1 empty=1",
                   PcOut, IfIdPc, IfIdValid, RasEmpty);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if (PcOut !== 32'h200 || IfIdValid !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_release got pc=%h vld=%b want pc=00000200 vld=0", PcOut, IfIdValid);
        end
      end
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       cycle(3'b000, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0, 32'h0);
        1:       cycle(3'b001, 1'b1, 1'b0, 1'b1, 32'h100, 32'h300, 32'h0, 32'h0);
        2:       cycle(3'b100, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0,   32'h0, 32'h0);
        3:       cycle(3'b011, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0,   32'h0, 32'h605);
        default: cycle(3'b100, 1'b1, 1'b0, 1'b1, 32'h700, 32'h0,   32'h0, 32'h0);
      endcase
      exp_o = sb.pop_front();
      act_o = sample_dut();
      n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL callret_sb[%0d] got %h want %h", i, act_o, exp_o);
      end
      if (i == 2 || i == 4) begin
        n_cmp++;
        if (PcOut !== ((i == 2) ? 32'h104 : 32'h204) || RasEmpty !== 1'b1) begin
          n_fail++;
          $display("FAIL callret_ret[%0d] got pc=%h empty=%b want pc=%h empty=1",
                   i, PcOut, RasEmpty, (i == 2) ? 32'h104 : 32'h204);
        end
      end
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] want;
    do_reset();
    cycle(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    void'(sb.pop_front());
    for (int i = 0; i < 18; i++) begin
      if (i < 9) cycle(3'b000, 1'b0, 1'b0, 1'b1, 32'h1000 + 32'(16 * i), 32'h0, 32'h0, 32'h0);
      else cycle(3'b100, 1'b1, 1'b0, 1'b0, 32'h8000, 32'h0, 32'h0, 32'h0);
      exp_o = sb.pop_front();
      act_o = sample_dut();
      n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL ras_sb[%0d] got %h want %h", i, act_o, exp_o);
      end
      if (i == 8) begin
        n_cmp++;
        if (RasFull !== 1'b1 || RasEmpty !== 1'b0) begin
          n_fail++;
          $display("FAIL ras_full got full=%b empty=%b want full=1 empty=0", RasFull, RasEmpty);
        end
      end
      if (i >= 9) begin
        want = (i == 17) ? 32'h8004 : 32'h1004 + 32'(16 * (17 - i));
        n_cmp++;
        if (PcOut !== want || RasUnderflow !== (i == 17)) begin
          n_fail++;
          $display("FAIL ras_pop[%0d] got pc=%h uf=%b want pc=%h uf=%b",
                   i - 8, PcOut, RasUnderflow, want, (i == 17));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(3'b000, 1'b0, 1'b0, (i == 1), 32'h40, 32'h0, 32'h0, 32'h0);
      void'(sb.pop_front());
    end
    PcSource = 3'b001; JumpTarget = 32'h900; SIG_Kill = 1'b1; SIG_RasPush = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    act_o = sample_dut();
    n_cmp++;
    if (act_o !== RST_OBS) begin
      n_fail++;
      $display("FAIL async_reset_now got %h want %h", act_o, RST_OBS);
    end
    model_reset();
    @(posedge clk);
    #1;
    act_o = sample_dut();
    n_cmp++;
    if (act_o !== RST_OBS) begin
      n_fail++;
      $display("FAIL async_reset_hold got %h want %h", act_o, RST_OBS);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      exp_o = sb.pop_front();
      act_o = sample_dut();
      n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL restart_sb[%0d] got %h want %h", i, act_o, exp_o);
      end
    end
    n_cmp++;
    if (PcOut !== 32'h8 || IfIdPc !== 32'h4 || RasEmpty !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_pc got pc=%h ifpc=%h empty=%b want pc=00000008 ifpc=00000004 empty=1",
               PcOut, IfIdPc, RasEmpty);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 80; i++) begin
      cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            $urandom(), $urandom(), $urandom(), $urandom());
      exp_o = sb.pop_front();
      act_o = sample_dut();
      n_cmp++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL random_sb[%0d] got %h want %h", i, act_o, exp_o);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_stall_kill();
    test_call_ret();
    test_ras_overflow();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
